// File: rtl/program_fetch_unit_pkg.sv
// program_fetch_unit_pkg: shared text base, fetch state encoding, buffer entry and address legality
package program_fetch_unit_pkg;
   localparam logic [31:0] TEXT_BASE_DEF = 32'h0040_0000;
   typedef enum logic {RUN, FAULT} state_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;
   localparam int ENTRY_W = $bits(entry_t);
   function automatic logic addr_legal(input logic [31:0] a, input logic [31:0] base, input int unsigned depth);
      logic [32:0] lo;
      logic [32:0] hi;
      lo = {1'b0, base};
      hi = lo + 33'(depth) * 33'd4;
      return a[1:0] == 2'b00 && {1'b0, a} >= lo && {1'b0, a} < hi;
   endfunction
endpackage

// File: rtl/program_fetch_unit_fetch_buffer.sv
// fetch_buffer: small synchronous FIFO with flush; empty head reads as zero
module fetch_buffer #(
   parameter int W = 64,
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count
);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] rd, wr;
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd <= '0;
         wr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wr] <= din;
            wr <= wr + AW'(1);
         end
         if (pop) rd <= rd + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   assign dout = count == '0 ? '0 : mem[rd];
endmodule

// File: rtl/program_fetch_unit.sv
// program_fetch_unit: fetch PC sequencer with prefetch buffer, redirect flush and illegal-address fault
module program_fetch_unit
   import program_fetch_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEMORY_DEPTH = 64,
   parameter logic [31:0] TEXT_BASE = TEXT_BASE_DEF,
   parameter int BUF_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [DATA_WIDTH-1:0] Mem_Address_o,
   input  logic [DATA_WIDTH-1:0] Mem_Instruction_i,
   input  logic                  Redirect_i,
   input  logic [DATA_WIDTH-1:0] Redirect_Target_i,
   output logic                  Instr_Valid_o,
   input  logic                  Instr_Ready_i,
   output logic [DATA_WIDTH-1:0] Instruction_o,
   output logic [DATA_WIDTH-1:0] Instr_PC_o,
   output logic                  Fault_o,
   output logic [DATA_WIDTH-1:0] Fault_Addr_o
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   state_t state, state_n;
   logic [DATA_WIDTH-1:0] fetch_pc, fetch_pc_n, fault_addr_n;
   logic [CW-1:0] count;
   logic legal, push, pop;
   entry_t din, dout;
   assign legal = addr_legal(fetch_pc, TEXT_BASE, MEMORY_DEPTH);
   assign Instr_Valid_o = count != '0 && !Redirect_i;
   assign pop = Instr_Valid_o && Instr_Ready_i;
   assign push = state == RUN && !Redirect_i && legal && (count < CW'(BUF_DEPTH) || pop);
   assign din = '{pc: fetch_pc, instr: Mem_Instruction_i};
   assign Mem_Address_o = fetch_pc;
   assign Instruction_o = dout.instr;
   assign Instr_PC_o = dout.pc;
   assign Fault_o = state == FAULT;
   always_comb begin
      state_n = state;
      fetch_pc_n = fetch_pc;
      fault_addr_n = Fault_Addr_o;
      if (Redirect_i) begin
         state_n = RUN;
         fetch_pc_n = Redirect_Target_i;
      end else if (state == RUN && !legal) begin
         state_n = FAULT;
         fault_addr_n = fetch_pc;
      end else if (push) begin
         fetch_pc_n = fetch_pc + DATA_WIDTH'(4);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         fetch_pc <= TEXT_BASE;
         Fault_Addr_o <= '0;
      end else begin
         state <= state_n;
         fetch_pc <= fetch_pc_n;
         Fault_Addr_o <= fault_addr_n;
      end
   end
   fetch_buffer #(.W(ENTRY_W), .DEPTH(BUF_DEPTH)) u_buf (
      .clk(clk),
      .reset(reset),
      .push(push),
      .pop(pop),
      .flush(Redirect_i),
      .din(din),
      .dout(dout),
      .count(count)
   );
endmodule

// File: doc/program_fetch_unit.md
Name: program_fetch_unit

Overview:
- Sequences the combinational single-port program memory and delivers instructions to decode over a valid/ready handshake.
- Owns the fetch PC, which resets to the text-segment base.
- Prefetches into a small instruction buffer and flushes on branch/jump redirect.
- Flags misaligned or out-of-range fetch addresses instead of wrapping.
- Sits between the PC/branch logic and Program_Memory.

Parameters:
- DATA_WIDTH, 32: address and instruction width.
- MEMORY_DEPTH, 64: program memory depth in words; the legal fetch range is derived from it.
- TEXT_BASE, 32'h0040_0000: byte address of memory word 0 and the reset PC.
- BUF_DEPTH, 2: instruction buffer entries (power of 2, at least 2).

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- Mem_Address_o  out  32  Byte address driven to program memory; equals the fetch PC.
- Mem_Instruction_i  in  32  Combinational read data from program memory for Mem_Address_o.
- Redirect_i  in  1  Branch/jump taken: flush and refetch from Redirect_Target_i.
- Redirect_Target_i  in  32  New fetch byte address.
- Instr_Valid_o  out  1  Head buffer entry is available.
- Instr_Ready_i  in  1  Decode accepts the head entry.
- Instruction_o  out  32  Head entry instruction.
- Instr_PC_o  out  32  Head entry byte address.
- Fault_o  out  1  Fetch stopped on an illegal address.
- Fault_Addr_o  out  32  Offending fetch address; holds while Fault_o is 1.

Behaviour:
- Reset (synchronous, edge with reset=1):
  - fetch_pc=TEXT_BASE, buffer count=0, state=RUN.
  - Fault_o=0, Fault_Addr_o=0, Instr_Valid_o=0.
  - Instruction_o and Instr_PC_o=0 while the buffer is empty.
  - Mem_Address_o=TEXT_BASE.
  - Reset overrides every other input, including mid-fault and mid-redirect.
- States: RUN and FAULT.
- Legal address: low two bits are 00, addr >= TEXT_BASE, and addr < TEXT_BASE + 4*MEMORY_DEPTH. Compare in 33-bit arithmetic so there is no overflow wrap.
- pop = Instr_Valid_o & Instr_Ready_i.
- Push condition (RUN, no redirect): fetch_pc is legal and (count < BUF_DEPTH or pop).
  - On push, the entry {fetch_pc, Mem_Instruction_i} is written and fetch_pc += 4.
- Simultaneous push and pop when full is allowed; count is unchanged.
- Pop when empty is impossible because valid is 0.
- RUN with illegal fetch_pc and no redirect:
  - No push.
  - Next state is FAULT; Fault_Addr_o <= fetch_pc.
  - Buffered entries still drain normally.
- FAULT:
  - No fetches; fetch_pc holds; Fault_o=1.
  - Exit only via Redirect_i (back to RUN, even if the target is illegal; it re-faults next cycle) or reset.
- Redirect_i=1 (priority over push, pop and fault):
  - Instr_Valid_o is forced to 0 combinationally in that cycle, so no handshake occurs.
  - At the edge: buffer count=0, fetch_pc <= Redirect_Target_i, state=RUN, Fault_o cleared.
- Latency:
  - The fetch at edge E makes the instruction visible with Instr_Valid_o=1 from cycle E+1.
  - After reset is released (first RUN edge = edge 0), valid is high from cycle 1 with PC 0x00400000.
  - After a redirect at edge R, the target instruction is valid from cycle R+2.
- Stalled decode (Instr_Ready_i=0): the buffer fills to BUF_DEPTH and the fetch PC holds.
  - Mem_Address_o remains stable at the next PC.
- Buffer ordering: strict FIFO; head outputs are held stable while valid and not ready.
- PC sequencing never wraps: fetching past the last word faults at TEXT_BASE + 4*MEMORY_DEPTH.

Decomposition:
- Shared package holds:
  - TEXT_BASE default.
  - State encoding (RUN, FAULT).
  - Fetch-entry struct/width {pc[31:0], instr[31:0]}.
  - Address-legality function.
- One natural sub-module: fetch_buffer.
  - Parameterised BUF_DEPTH synchronous FIFO of 64-bit entries.
  - Push/pop/flush with simultaneous push-pop when full.
  - Count, head data.
  - Synchronous active-high reset.

Test Plan:
- Reset, then Instr_Ready_i=1 constant with memory preloaded with word index i:
  - Instr_Valid_o rises at cycle 1.
  - Instr_PC_o sequence is 0x00400000, 0x00400004, ... with Instruction_o = i.
  - One instruction per cycle.
- Hold Instr_Ready_i=0 for 5 cycles:
  - Count saturates at 2; Mem_Address_o stays at 0x00400008.
  - On release, instructions at 0x00400000 and 0x00400004 are delivered in order with no loss or duplication.
- Redirect_i=1 with target 0x00400040 while the buffer is full:
  - Instr_Valid_o=0 in that cycle; the buffer is flushed.
  - The next delivered PC is 0x00400040 at R+2.
  - Previously buffered PCs never appear.
- Sequential fetch reaching 0x00400100 (MEMORY_DEPTH=64):
  - The last delivered PC is 0x004000FC.
  - Fault_o=1 with Fault_Addr_o=0x00400100.
  - No further valid entries.
  - A redirect to 0x00400000 clears the fault and resumes fetching.
- Redirect to 0x00400002 and, separately, to 0x003FFFFC:
  - Fault_o=1 the following cycle with Fault_Addr_o equal to the target.
  - No valid entries delivered.
- Assert reset during FAULT and during a partially filled buffer:
  - On the next edge, all outputs return to reset values and fetch restarts at 0x00400000.
